// File: rtl/glove_pkg.sv
// Glove link shared definitions: command codes and code type.
// Used by the master-board receiver and the glove transmitter.
package glove_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_T     = 4'd0;
  localparam cmd_t CMD_B     = 4'd1;
  localparam cmd_t CMD_L     = 4'd2;
  localparam cmd_t CMD_R     = 4'd3;
  localparam cmd_t CMD_BTN_L = 4'd4;
  localparam cmd_t CMD_BTN_U = 4'd6;
  localparam cmd_t CMD_BTN_D = 4'd7;
  localparam cmd_t CMD_BTN_C = 4'd8;
  localparam cmd_t CMD_MAX   = 4'd8;

endpackage

// File: rtl/glove_cmd_receiver_if.sv
// Command delivery bus: valid/ready handshake carrying one code.
// master: cmd_valid/cmd_code out, cmd_ready in; slave: reverse.
interface glove_cmd_receiver_if;
  import glove_pkg::*;

  logic cmd_valid;
  cmd_t cmd_code;
  logic cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_code,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    output cmd_ready
  );

endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop sync, 16x oversample timer, rx FSM.
// Ports: clk, rst, i_rx in; o_byte, o_byte_stb, o_frame_err_stb out.
module uart_rx_8n1 #(
  parameter int DIV = 651
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_stb,
  output logic       o_frame_err_stb
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_t;

  rx_state_t      r_state;
  rx_state_t      w_state_nx;
  logic           r_sync1;
  logic           r_sync2;
  logic [TW-1:0]  r_tick_cnt;
  logic [TW-1:0]  w_tick_cnt_nx;
  logic [3:0]     r_smp;
  logic [3:0]     w_smp_nx;
  logic [2:0]     r_bit_cnt;
  logic [2:0]     w_bit_cnt_nx;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_nx;
  logic           r_byte_stb;
  logic           w_byte_stb_nx;
  logic           r_ferr_stb;
  logic           w_ferr_stb_nx;
  logic           w_tick;

  assign w_tick = (r_tick_cnt == TW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_smp      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte_stb <= 1'b0;
      r_ferr_stb <= 1'b0;
    end else begin
      r_sync1    <= i_rx;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nx;
      r_tick_cnt <= w_tick_cnt_nx;
      r_smp      <= w_smp_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_shift    <= w_shift_nx;
      r_byte_stb <= w_byte_stb_nx;
      r_ferr_stb <= w_ferr_stb_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_tick_cnt_nx = w_tick ? '0 : r_tick_cnt + 1'b1;
    w_smp_nx      = r_smp;
    w_bit_cnt_nx  = r_bit_cnt;
    w_shift_nx    = r_shift;
    w_byte_stb_nx = 1'b0;
    w_ferr_stb_nx = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // hold the timer so it restarts on the start edge
        w_tick_cnt_nx = '0;
        w_smp_nx      = '0;
        if (!r_sync2) begin
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_smp == 4'd7) begin
            w_smp_nx     = '0;
            w_bit_cnt_nx = '0;
            w_state_nx   = r_sync2 ? S_IDLE : S_DATA;
          end else begin
            w_smp_nx = r_smp + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_smp_nx = r_smp + 4'd1;
          if (r_smp == 4'd15) begin
            w_shift_nx   = {r_sync2, r_shift[7:1]};
            w_bit_cnt_nx = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_nx = S_STOP;
            end
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_smp_nx = r_smp + 4'd1;
          if (r_smp == 4'd15) begin
            if (r_sync2) begin
              w_byte_stb_nx = 1'b1;
              w_state_nx    = S_IDLE;
            end else begin
              w_ferr_stb_nx = 1'b1;
              w_state_nx    = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        // a held-low line must not look like a stream of starts
        w_tick_cnt_nx = '0;
        if (r_sync2) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign o_byte          = r_shift;
  assign o_byte_stb      = r_byte_stb;
  assign o_frame_err_stb = r_ferr_stb;

endmodule

// File: rtl/glove_cmd_receiver.sv
// Glove command receiver: UART rx, code check, FIFO, rts, errors.
// Ports: clk, rst, i_rx in; o_rts, o_err_frame, o_err_cnt out; cmd bus.
module glove_cmd_receiver
  import glove_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_rx,
  output logic                       o_rts,
  output logic                       o_err_frame,
  output logic [7:0]                 o_err_cnt,
  glove_cmd_receiver_if.master       cmd
);

  localparam int DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;

  logic [7:0]    w_byte;
  logic          w_byte_stb;
  logic          w_ferr_stb;
  logic          w_code_ok;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [PW-1:0] w_occ;
  logic [PW-1:0] w_occ_nx;

  cmd_t          r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_valid;
  logic          r_rts;
  logic          r_err_frame;
  logic [7:0]    r_err_cnt;

  uart_rx_8n1 #(
    .DIV (DIV)
  ) u_rx (
    .clk             (clk),
    .rst             (rst),
    .i_rx            (i_rx),
    .o_byte          (w_byte),
    .o_byte_stb      (w_byte_stb),
    .o_frame_err_stb (w_ferr_stb)
  );

  assign w_code_ok = (w_byte <= {4'd0, CMD_MAX});
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = r_valid && cmd.cmd_ready;
  // a pop in the same cycle frees the slot a full FIFO lacks
  assign w_push    = w_byte_stb && w_code_ok && (!w_full || w_pop);
  assign w_drop    = w_ferr_stb || (w_byte_stb && !w_push);
  assign w_occ     = r_wptr - r_rptr;
  assign w_occ_nx  = w_occ + PW'(w_push) - PW'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_valid     <= 1'b0;
      r_rts       <= 1'b0;
      r_err_frame <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= w_byte[3:0];
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_valid <= (w_occ_nx != '0);
      r_rts   <= (w_occ_nx >= PW'(FIFO_DEPTH - 2));
      if (w_ferr_stb) begin
        r_err_frame <= 1'b1;
      end
      if (w_drop && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign cmd.cmd_valid = r_valid;
  assign cmd.cmd_code  = r_valid ? r_mem[r_rptr[AW-1:0]] : '0;
  assign o_rts         = r_rts;
  assign o_err_frame   = r_err_frame;
  assign o_err_cnt     = r_err_cnt;

endmodule
